// File: rtl/except_ctrl.sv
// except_ctrl -- exception decode and trap sequencer between ID and the CSR unit.
//
// Each accepted instruction is decoded for ECALL, EBREAK and MRET, and for
// NUM_EXT external fault flags. The highest-priority event is selected.
// A trap writes mepc, then mcause (and optionally mtval) to the CSR unit over
// successive cycles. It then issues a one-cycle redirect to mtvec.
// An MRET issues a one-cycle redirect to mepc.
// ID is stalled through O_ready while a sequence is in flight.
//
// Build option: define EXCEPT_MTVAL_EN to add the mtval write state (W_TVAL).
// This writes I_inst_bad, latched at accept, to mtval.
// Without the option, I_inst_bad is unused and mtval is never written.
//
// Ports:
//   I_clk, I_rst_n          clock, synchronous active-low reset
//   I_valid / O_ready       ID handshake, transfer = I_valid & O_ready
//   I_inst, I_pc            instruction word and its PC
//   I_ext_except[NUM_EXT]   external fault flags, index 0 = highest priority
//   I_inst_bad              faulting value for mtval
//   I_mtvec, I_mepc         current CSR values, used for the redirect target
//   O_csr_we/waddr/wdata    CSR write port
//   O_redirect(_pc)         one-cycle flush/redirect pulse and its target
//   O_busy                  sequence in flight (= ~O_ready)
module except_ctrl #(
  parameter int                   XLEN      = 32,
  parameter int                   NUM_EXT   = 2,
  parameter logic [NUM_EXT*4-1:0] EXT_CAUSE = {4'd0, 4'd2}
) (
  input  logic                I_clk,
  input  logic                I_rst_n,
  input  logic                I_valid,
  output logic                O_ready,
  input  logic [31:0]         I_inst,
  input  logic [XLEN-1:0]     I_pc,
  input  logic [NUM_EXT-1:0]  I_ext_except,
  input  logic [XLEN-1:0]     I_inst_bad,
  input  logic [XLEN-1:0]     I_mtvec,
  input  logic [XLEN-1:0]     I_mepc,
  output logic                O_csr_we,
  output logic [11:0]         O_csr_waddr,
  output logic [XLEN-1:0]     O_csr_wdata,
  output logic                O_redirect,
  output logic [XLEN-1:0]     O_redirect_pc,
  output logic                O_busy
);

  localparam logic [31:0] ECALL  = 32'h00000073;
  localparam logic [31:0] EBREAK = 32'h00100073;
  localparam logic [31:0] MRET   = 32'h30200073;

  localparam logic [11:0] CSR_MEPC   = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;
`ifdef EXCEPT_MTVAL_EN
  localparam logic [11:0] CSR_MTVAL  = 12'h343;
`endif

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    W_EPC   = 3'd1,
    W_CAUSE = 3'd2,
`ifdef EXCEPT_MTVAL_EN
    W_TVAL  = 3'd3,
`endif
    REDIR   = 3'd4
  } state_t;

  state_t          state, state_d;
  logic [3:0]      cause_q;
`ifdef EXCEPT_MTVAL_EN
  logic [XLEN-1:0] bad_q;
`else
  logic            unused_bad;
  assign unused_bad = ^I_inst_bad;
`endif
  logic            unused_tvec;
  assign unused_tvec = ^I_mtvec[1:0];

  // Decode
  logic       accept, ext_any, is_ecall, is_ebreak, is_mret, trap;
  logic [3:0] ext_cause, cause_sel;

  assign accept    = I_valid & (state == IDLE);
  assign ext_any   = |I_ext_except;
  assign is_ecall  = (I_inst == ECALL);
  assign is_ebreak = (I_inst == EBREAK);
  assign is_mret   = (I_inst == MRET) & ~ext_any;
  assign trap      = ext_any | is_ecall | is_ebreak;

  // The loop runs low-priority first, so the lowest set index wins.
  always_comb begin
    ext_cause = 4'd0;
    for (int i = NUM_EXT - 1; i >= 0; i--)
      if (I_ext_except[i]) ext_cause = EXT_CAUSE[4*i +: 4];
  end

  always_comb begin
    cause_sel = 4'd11;
    if (ext_any)        cause_sel = ext_cause;
    else if (is_ebreak) cause_sel = 4'd3;
  end

  // Output regs
  logic            we_d, redir_d;
  logic [11:0]     waddr_d;
  logic [XLEN-1:0] wdata_d, rpc_d;

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (accept && trap)         state_d = W_EPC;
               else if (accept && is_mret) state_d = REDIR;
      W_EPC:   state_d = W_CAUSE;
`ifdef EXCEPT_MTVAL_EN
      W_CAUSE: state_d = W_TVAL;
      W_TVAL:  state_d = REDIR;
`else
      W_CAUSE: state_d = REDIR;
`endif
      REDIR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed for the state being entered and registered,
  // so they line up with the cycle the FSM occupies that state.
  always_comb begin
    we_d    = 1'b0;
    waddr_d = 12'h000;
    wdata_d = '0;
    redir_d = 1'b0;
    rpc_d   = '0;
    case (state_d)
      W_EPC: begin
        // W_EPC is only entered from IDLE on accept, so I_pc is the trapping PC.
        we_d    = 1'b1;
        waddr_d = CSR_MEPC;
        wdata_d = I_pc;
      end
      W_CAUSE: begin
        we_d    = 1'b1;
        waddr_d = CSR_MCAUSE;
        wdata_d = {{(XLEN-4){1'b0}}, cause_q};
      end
`ifdef EXCEPT_MTVAL_EN
      W_TVAL: begin
        we_d    = 1'b1;
        waddr_d = CSR_MTVAL;
        wdata_d = bad_q;
      end
`endif
      REDIR: begin
        // REDIR is entered straight from IDLE only for MRET.
        // From any other state, the source is a trap.
        redir_d = 1'b1;
        rpc_d   = (state == IDLE) ? I_mepc : {I_mtvec[XLEN-1:2], 2'b00};
      end
      default: ;
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      state         <= IDLE;
      cause_q       <= 4'd0;
      O_csr_we      <= 1'b0;
      O_csr_waddr   <= 12'h000;
      O_csr_wdata   <= '0;
      O_redirect    <= 1'b0;
      O_redirect_pc <= '0;
      O_busy        <= 1'b0;
    end else begin
      state         <= state_d;
      if (accept) cause_q <= cause_sel;
      O_csr_we      <= we_d;
      O_csr_waddr   <= waddr_d;
      O_csr_wdata   <= wdata_d;
      O_redirect    <= redir_d;
      O_redirect_pc <= rpc_d;
      O_busy        <= (state_d != IDLE);
    end
  end

`ifdef EXCEPT_MTVAL_EN
  always_ff @(posedge I_clk) begin
    if (!I_rst_n)    bad_q <= '0;
    else if (accept) bad_q <= I_inst_bad;
  end
`endif

  assign O_ready = ~O_busy;

endmodule

// File: tb/tb_except_ctrl.sv
// Directed bench for except_ctrl.
// Inputs are driven 1 ns after the rising edge, and outputs are sampled there too.
// EXT_CAUSE is overridden so that source 0 has cause 0 and source 1 has cause 2 (illegal).
module tb_except_ctrl;

  logic        I_clk = 1'b0;
  logic        I_rst_n;
  logic        I_valid;
  logic        O_ready;
  logic [31:0] I_inst;
  logic [31:0] I_pc;
  logic [1:0]  I_ext_except;
  logic [31:0] I_inst_bad;
  logic [31:0] I_mtvec;
  logic [31:0] I_mepc;
  logic        O_csr_we;
  logic [11:0] O_csr_waddr;
  logic [31:0] O_csr_wdata;
  logic        O_redirect;
  logic [31:0] O_redirect_pc;
  logic        O_busy;

  except_ctrl #(.XLEN(32), .NUM_EXT(2), .EXT_CAUSE(8'h20)) dut (
    .I_clk(I_clk), .I_rst_n(I_rst_n), .I_valid(I_valid), .O_ready(O_ready),
    .I_inst(I_inst), .I_pc(I_pc), .I_ext_except(I_ext_except),
    .I_inst_bad(I_inst_bad), .I_mtvec(I_mtvec), .I_mepc(I_mepc),
    .O_csr_we(O_csr_we), .O_csr_waddr(O_csr_waddr), .O_csr_wdata(O_csr_wdata),
    .O_redirect(O_redirect), .O_redirect_pc(O_redirect_pc), .O_busy(O_busy)
  );

  always #5 I_clk = ~I_clk;

  localparam logic [31:0] ECALL  = 32'h00000073;
  localparam logic [31:0] EBREAK = 32'h00100073;
  localparam logic [31:0] MRET   = 32'h30200073;
  localparam logic [31:0] NOP    = 32'h00000013;
`ifdef EXCEPT_MTVAL_EN
  localparam int WPT = 3;
`else
  localparam int WPT = 2;
`endif

  int checks = 0;
  int errors = 0;
  int n_we = 0, n_redir = 0, n_cause3 = 0;

  always @(negedge I_clk) begin
    if (O_csr_we) n_we++;
    if (O_redirect) n_redir++;
    if (O_csr_we && O_csr_waddr == 12'h342 && O_csr_wdata == 32'd3) n_cause3++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge I_clk);
    #1;
  endtask

  // Accept happens at the next edge. This task walks through cycles N+1 to N+4 (or N+5).
  task automatic trap_seq(input string tag, input logic [31:0] pc, input logic [31:0] cause,
                          input logic [31:0] bad, input logic [31:0] tgt,
                          input logic [31:0] next_pc, input logic drop);
    tick();
    chk({tag, " epc_we"},   {31'b0, O_csr_we}, 32'd1);
    chk({tag, " epc_addr"}, {20'b0, O_csr_waddr}, 32'h341);
    chk({tag, " epc_data"}, O_csr_wdata, pc);
    chk({tag, " epc_rdy"},  {31'b0, O_ready}, 32'd0);
    chk({tag, " epc_busy"}, {31'b0, O_busy}, 32'd1);
    I_pc       = next_pc;
    I_inst_bad = 32'h0;
    if (drop) I_valid = 1'b0;
    tick();
    chk({tag, " cause_we"},   {31'b0, O_csr_we}, 32'd1);
    chk({tag, " cause_addr"}, {20'b0, O_csr_waddr}, 32'h342);
    chk({tag, " cause_data"}, O_csr_wdata, cause);
    chk({tag, " cause_rdy"},  {31'b0, O_ready}, 32'd0);
`ifdef EXCEPT_MTVAL_EN
    tick();
    chk({tag, " tval_addr"}, {20'b0, O_csr_waddr}, 32'h343);
    chk({tag, " tval_data"}, O_csr_wdata, bad);
`else
    if (bad != 32'h0) chk({tag, " no_tval"}, {20'b0, O_csr_waddr}, 32'h342);
`endif
    tick();
    chk({tag, " redir"},    {31'b0, O_redirect}, 32'd1);
    chk({tag, " redir_pc"}, O_redirect_pc, tgt);
    chk({tag, " redir_we"}, {31'b0, O_csr_we}, 32'd0);
    chk({tag, " redir_rdy"}, {31'b0, O_ready}, 32'd0);
    tick();
    chk({tag, " end_redir"}, {31'b0, O_redirect}, 32'd0);
    chk({tag, " end_rdy"},   {31'b0, O_ready}, 32'd1);
    chk({tag, " end_we"},    {31'b0, O_csr_we}, 32'd0);
  endtask

  initial begin
    I_rst_n = 1'b0; I_valid = 1'b0; I_inst = NOP; I_pc = 32'h0;
    I_ext_except = 2'b00; I_inst_bad = 32'h0;
    I_mtvec = 32'h80000100; I_mepc = 32'h11111110;
    tick(); tick();
    chk("rst ready", {31'b0, O_ready}, 32'd1);
    chk("rst busy",  {31'b0, O_busy}, 32'd0);
    chk("rst we",    {31'b0, O_csr_we}, 32'd0);
    chk("rst redir", {31'b0, O_redirect}, 32'd0);
    chk("rst addr",  {20'b0, O_csr_waddr}, 32'h0);
    chk("rst data",  O_csr_wdata, 32'h0);
    chk("rst rpc",   O_redirect_pc, 32'h0);
    I_rst_n = 1'b1;

    // No-event transfer
    I_valid = 1'b1; I_inst = NOP; I_pc = 32'h80000008;
    tick();
    chk("nop ready", {31'b0, O_ready}, 32'd1);
    chk("nop we",    {31'b0, O_csr_we}, 32'd0);
    chk("nop redir", {31'b0, O_redirect}, 32'd0);

    // ECALL with I_valid held high: a second ECALL must wait until ready returns
    I_inst = ECALL; I_pc = 32'h80000010;
    trap_seq("ecall1", 32'h80000010, 32'd11, 32'h0, 32'h80000100, 32'h80000020, 1'b0);
    trap_seq("ecall2", 32'h80000020, 32'd11, 32'h0, 32'h80000100, 32'h80000020, 1'b1);
    tick();
    chk("idle after ecall2", {31'b0, O_busy}, 32'd0);

    // EBREAK + ext[0]: ext wins, cause 0; mtvec low bits masked
    I_mtvec = 32'h80000203;
    I_valid = 1'b1; I_inst = EBREAK; I_pc = 32'h80000040; I_ext_except = 2'b01;
    trap_seq("ebrk_ext0", 32'h80000040, 32'd0, 32'h0, 32'h80000200, 32'h0, 1'b1);
    I_ext_except = 2'b00;

    // Both ext flags set: source 0 has priority
    I_valid = 1'b1; I_inst = ECALL; I_pc = 32'h80000050; I_ext_except = 2'b11;
    trap_seq("ext_pri", 32'h80000050, 32'd0, 32'h0, 32'h80000200, 32'h0, 1'b1);

    // ext[1] illegal with mtval
    I_mtvec = 32'h80000100;
    I_valid = 1'b1; I_inst = 32'hFFFFFFFF; I_pc = 32'h80000060; I_ext_except = 2'b10;
    I_inst_bad = 32'hDEADBEEF;
    trap_seq("ext1", 32'h80000060, 32'd2, 32'hDEADBEEF, 32'h80000100, 32'h0, 1'b1);
    I_ext_except = 2'b00;

    // MRET
    I_mepc = 32'h80000014;
    I_valid = 1'b1; I_inst = MRET; I_pc = 32'h80000070;
    tick();
    I_valid = 1'b0;
    chk("mret redir",    {31'b0, O_redirect}, 32'd1);
    chk("mret redir_pc", O_redirect_pc, 32'h80000014);
    chk("mret we",       {31'b0, O_csr_we}, 32'd0);
    chk("mret rdy",      {31'b0, O_ready}, 32'd0);
    tick();
    chk("mret end_rdy",   {31'b0, O_ready}, 32'd1);
    chk("mret end_redir", {31'b0, O_redirect}, 32'd0);

    // Reset entering N+2 aborts the trap
    I_valid = 1'b1; I_inst = ECALL; I_pc = 32'h80000030;
    tick();
    chk("abort epc_we", {31'b0, O_csr_we}, 32'd1);
    I_valid = 1'b0; I_rst_n = 1'b0;
    tick();
    chk("abort we",    {31'b0, O_csr_we}, 32'd0);
    chk("abort redir", {31'b0, O_redirect}, 32'd0);
    chk("abort addr",  {20'b0, O_csr_waddr}, 32'h0);
    chk("abort ready", {31'b0, O_ready}, 32'd1);
    I_rst_n = 1'b1;
    tick(); tick(); tick(); tick();
    chk("abort idle", {31'b0, O_busy}, 32'd0);

    // Totals: 5 traps and 1 MRET redirect, plus 1 aborted mepc write
    chk("n_redir",  n_redir, 32'd6);
    chk("n_we",     n_we, 5 * WPT + 1);
    chk("n_cause3", n_cause3, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
